// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Function : integer register file with per-register pending-write counters.
//            Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback.
// Revision : 1.0
// ============================================================================
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int PEND_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] rdValue,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  output logic            wb_underflow
);

  localparam logic [PEND_W-1:0] c_CNT_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] c_CNT_ONE = PEND_W'(1);

  logic [XLEN-1:0]   r_regs [NREGS];
  logic [PEND_W-1:0] r_cnt  [NREGS];
  logic              r_underflow;

  logic w_wb;
  logic w_issue_inc;
  logic w_same_reg;
  logic w_underflow_evt;

  assign w_wb        = we && (rd != 5'd0);
  assign issue_ready = (issue_rd == 5'd0) || (r_cnt[issue_rd] != c_CNT_MAX);
  assign w_issue_inc = issue_valid && issue_ready && (issue_rd != 5'd0);
  // Issue and writeback to one register cancel: no count change, no underflow.
  assign w_same_reg      = w_issue_inc && w_wb && (issue_rd == rd);
  assign w_underflow_evt = w_wb && !w_same_reg && (r_cnt[rd] == '0);
  assign wb_underflow    = r_underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        r_regs[r] <= '0;
        r_cnt[r]  <= '0;
      end
      r_underflow <= 1'b0;
    end else begin
      if (w_wb) begin
        r_regs[rd] <= rdValue;
      end
      for (int r = 1; r < NREGS; r++) begin
        if (!w_same_reg) begin
          if (w_issue_inc && (issue_rd == 5'(r))) begin
            r_cnt[r] <= r_cnt[r] + c_CNT_ONE;
          end else if (w_wb && (rd == 5'(r)) && (r_cnt[r] != '0)) begin
            r_cnt[r] <= r_cnt[r] - c_CNT_ONE;
          end
        end
      end
      if (w_underflow_evt) begin
        r_underflow <= 1'b1;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic w_fwd1;
  logic w_fwd2;
  logic w_retire1;
  logic w_retire2;

  assign w_fwd1 = w_wb && (rd == rs1_addr);
  assign w_fwd2 = w_wb && (rd == rs2_addr);
  // Last outstanding write retiring now, with no fresh issue to replace it.
  assign w_retire1 = w_fwd1 && (r_cnt[rs1_addr] == c_CNT_ONE)
                     && !(w_issue_inc && (issue_rd == rs1_addr));
  assign w_retire2 = w_fwd2 && (r_cnt[rs2_addr] == c_CNT_ONE)
                     && !(w_issue_inc && (issue_rd == rs2_addr));

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (rs1_addr != 5'd0) begin
      rs1_data = w_fwd1 ? rdValue : r_regs[rs1_addr];
      rs1_busy = (r_cnt[rs1_addr] != '0) && !w_retire1;
    end
    if (rs2_addr != 5'd0) begin
      rs2_data = w_fwd2 ? rdValue : r_regs[rs2_addr];
      rs2_busy = (r_cnt[rs2_addr] != '0) && !w_retire2;
    end
  end
`else
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (rs1_addr != 5'd0) begin
      rs1_data = r_regs[rs1_addr];
      rs1_busy = (r_cnt[rs1_addr] != '0);
    end
    if (rs2_addr != 5'd0) begin
      rs2_data = r_regs[rs2_addr];
      rs2_busy = (r_cnt[rs2_addr] != '0);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// Testbench for regfile_scoreboard: directed vector table, hand sequence,
// and randomized traffic against a behavioural model.
module tb_regfile_scoreboard;

  localparam int MAXC = 3;

  logic        clk = 1'b0;
  logic        rst, we, issue_valid;
  logic [4:0]  rd, rs1_addr, rs2_addr, issue_rd;
  logic [31:0] rdValue;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy, issue_ready, wb_underflow;

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .PEND_W(2)) dut (
    .clk(clk), .rst(rst), .we(we), .rd(rd), .rdValue(rdValue),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .wb_underflow(wb_underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain arrays of values and outstanding-write counts.
  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  bit          m_uf;

  typedef struct {
    logic        rst, we;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [4:0]  a1, a2;
    logic        iv;
    logic [4:0]  ird;
    logic [31:0] e_d1;
    logic        e_b1;
    logic [31:0] e_d2;
    logic        e_b2;
    logic        e_rdy;
    logic        e_uf;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(logic r, logic w, logic [4:0] d, logic [31:0] v,
                              logic [4:0] a1, logic [4:0] a2, logic iv, logic [4:0] ird,
                              logic [31:0] d1, logic b1, logic [31:0] d2, logic b2,
                              logic rdy, logic uf);
    vec_t t;
    t.rst = r; t.we = w; t.rd = d; t.val = v; t.a1 = a1; t.a2 = a2;
    t.iv = iv; t.ird = ird; t.e_d1 = d1; t.e_b1 = b1; t.e_d2 = d2;
    t.e_b2 = b2; t.e_rdy = rdy; t.e_uf = uf;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(logic r, logic w, logic [4:0] d, logic [31:0] v,
                       logic [4:0] a1, logic [4:0] a2, logic iv, logic [4:0] ird);
    rst = r; we = w; rd = d; rdValue = v;
    rs1_addr = a1; rs2_addr = a2; issue_valid = iv; issue_rd = ird;
  endtask

  function automatic bit m_ready();
    return (issue_rd == 0) || (m_cnt[issue_rd] < MAXC);
  endfunction

  function automatic bit m_issue_to(logic [4:0] a);
    return issue_valid && m_ready() && (issue_rd != 0) && (issue_rd == a);
  endfunction

  function automatic logic [31:0] m_data(logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && rd == a) return rdValue;
`endif
    return m_regs[a];
  endfunction

  function automatic bit m_busy(logic [4:0] a);
    int eff;
    if (a == 0) return 1'b0;
    eff = m_cnt[a];
`ifdef REGFILE_BYPASS_EN
    if (we && rd == a && !m_issue_to(a) && eff > 0) eff = eff - 1;
`endif
    return eff > 0;
  endfunction

  // Apply the spec's edge rules to the model using the inputs held this cycle.
  task automatic m_commit();
    bit acc;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_cnt[i] = 0; end
      m_uf = 0;
      return;
    end
    acc = issue_valid && m_ready() && issue_rd != 0;
    if (we && rd != 0) begin
      m_regs[rd] = rdValue;
      if (acc && issue_rd == rd) begin
        // net zero
      end else if (m_cnt[rd] > 0) m_cnt[rd] = m_cnt[rd] - 1;
      else m_uf = 1;
    end
    if (acc && !(we && rd == issue_rd)) m_cnt[issue_rd] = m_cnt[issue_rd] + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    m_commit();
    #1;
  endtask

  task automatic check_model(string tag);
    chk({tag, ".rs1_data"}, rs1_data, m_data(rs1_addr));
    chk({tag, ".rs2_data"}, rs2_data, m_data(rs2_addr));
    chk({tag, ".rs1_busy"}, 32'(rs1_busy), 32'(m_busy(rs1_addr)));
    chk({tag, ".rs2_busy"}, 32'(rs2_busy), 32'(m_busy(rs2_addr)));
    chk({tag, ".issue_ready"}, 32'(issue_ready), 32'(m_ready()));
    chk({tag, ".wb_underflow"}, 32'(wb_underflow), 32'(m_uf));
  endtask

  initial begin
    tbl[0]  = mk(1,1,5,32'hAA,5,0,1,5,        0,0,0,0,1,0);
    tbl[1]  = mk(0,0,0,0,5,0,0,5,             0,0,0,0,1,0);
    tbl[2]  = mk(0,0,0,0,3,0,1,3,             0,0,0,0,1,0);
    tbl[3]  = mk(0,0,0,0,3,0,0,0,             0,1,0,0,1,0);
    tbl[4]  = mk(0,1,3,32'hDEADBEEF,0,0,0,0,  0,0,0,0,1,0);
    tbl[5]  = mk(0,0,0,0,3,0,0,0,             32'hDEADBEEF,0,0,0,1,0);
    tbl[6]  = mk(0,0,0,0,7,0,1,7,             0,0,0,0,1,0);
    tbl[7]  = mk(0,0,0,0,7,0,1,7,             0,1,0,0,1,0);
    tbl[8]  = mk(0,0,0,0,7,0,1,7,             0,1,0,0,1,0);
    tbl[9]  = mk(0,0,0,0,7,0,1,7,             0,1,0,0,0,0);
    tbl[10] = mk(0,0,0,0,7,8,1,8,             0,1,0,0,1,0);
    tbl[11] = mk(0,0,0,0,7,8,1,7,             0,1,0,1,0,0);
    tbl[12] = mk(0,0,0,0,4,0,1,4,             0,0,0,0,1,0);
    tbl[13] = mk(0,1,4,32'h12,0,0,1,4,        0,0,0,0,1,0);
    tbl[14] = mk(0,0,0,0,4,0,0,0,             32'h12,1,0,0,1,0);
    tbl[15] = mk(0,1,0,32'hFFFFFFFF,0,0,1,0,  0,0,0,0,1,0);
    tbl[16] = mk(0,1,9,32'h99,10,0,0,0,       0,0,0,0,1,0);
    tbl[17] = mk(0,0,0,0,9,0,0,0,             32'h99,0,0,0,1,1);
    tbl[18] = mk(1,0,0,0,9,7,0,7,             32'h99,0,0,1,0,1);
    tbl[19] = mk(0,0,0,0,9,7,0,7,             0,0,0,0,1,0);
    tbl[20] = mk(0,1,11,32'h5,0,0,1,11,       0,0,0,0,1,0);
    tbl[21] = mk(0,0,0,0,11,4,0,0,            32'h5,0,0,0,1,0);

    drive(1,0,0,0,0,0,0,0);
    tick();
    tick();

    for (int i = 0; i < 22; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tbl[i].rst, tbl[i].we, tbl[i].rd, tbl[i].val,
            tbl[i].a1, tbl[i].a2, tbl[i].iv, tbl[i].ird);
      #3;
      chk({tag, ".rs1_data"}, rs1_data, tbl[i].e_d1);
      chk({tag, ".rs1_busy"}, 32'(rs1_busy), 32'(tbl[i].e_b1));
      chk({tag, ".rs2_data"}, rs2_data, tbl[i].e_d2);
      chk({tag, ".rs2_busy"}, 32'(rs2_busy), 32'(tbl[i].e_b2));
      chk({tag, ".issue_ready"}, 32'(issue_ready), 32'(tbl[i].e_rdy));
      chk({tag, ".wb_underflow"}, 32'(wb_underflow), 32'(tbl[i].e_uf));
      tick();
    end

    // Writeback in the cycle decode reads the same register.
    drive(0,0,0,0,0,0,1,3);
    tick();
    drive(0,1,3,32'hCAFEF00D,3,3,0,0);
    #3;
`ifdef REGFILE_BYPASS_EN
    chk("fwd.rs1_data", rs1_data, 32'hCAFEF00D);
    chk("fwd.rs1_busy", 32'(rs1_busy), 32'd0);
    chk("fwd.rs2_data", rs2_data, 32'hCAFEF00D);
`else
    chk("fwd.rs1_data", rs1_data, 32'h0);
    chk("fwd.rs1_busy", 32'(rs1_busy), 32'd1);
    chk("fwd.rs2_data", rs2_data, 32'h0);
`endif
    tick();
    drive(0,0,0,0,3,0,0,0);
    #3;
    chk("post.rs1_data", rs1_data, 32'hCAFEF00D);
    chk("post.rs1_busy", 32'(rs1_busy), 32'd0);
    chk("post.wb_underflow", 32'(wb_underflow), 32'd0);
    tick();

    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 7)),
            $urandom,
            5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)),
            ($urandom_range(0, 9) < 6),
            5'($urandom_range(0, 7)));
      #3;
      check_model($sformatf("rnd%0d", n));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Architectural integer register file plus per-register pending-write scoreboard. It is the consumer of the writeback stage's `we`/`rd`/`rdValue` port.
- Decode reads source operands here.
- Decode marks destinations pending on issue.
- Writeback commits values and retires pending marks.
- Decode stalls on `rs1_busy`/`rs2_busy`/`issue_ready`.

Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers; x0 hardwired to zero
- PEND_W, 2, width of per-register in-flight write counter; max outstanding writes per register = 2^PEND_W-1

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- we  input  1  writeback write enable
- rd  input  5  writeback destination register
- rdValue  input  XLEN  writeback data
- rs1_addr  input  5  source 1 index
- rs2_addr  input  5  source 2 index
- rs1_data  output  XLEN  source 1 value (combinational read)
- rs2_data  output  XLEN  source 2 value (combinational read)
- rs1_busy  output  1  source 1 has outstanding write
- rs2_busy  output  1  source 2 has outstanding write
- issue_valid  input  1  decode issuing an instruction that writes issue_rd
- issue_rd  input  5  destination of issuing instruction
- issue_ready  output  1  scoreboard can accept the issue this cycle
- wb_underflow  output  1  sticky error: writeback retired a register with zero pending count

Behaviour:
- Reset (rst=1 at edge):
  - all registers cleared to 0
  - all pending counters cleared to 0
  - wb_underflow cleared to 0
  - overrides any same-cycle we/issue
- Outputs after reset: rs*_data=0, rs*_busy=0, issue_ready=1.
- Register write: on edge with we=1 and rd!=0, regs[rd]<=rdValue. Writes to x0 are discarded.
- Reads: combinational, regs[rsN_addr]. Address 0 always returns 0 and busy=0.
- Pending counter cnt[r], PEND_W bits:
  - Issue handshake: accepted when issue_valid && issue_ready.
  - issue_ready = (issue_rd==0) || (cnt[issue_rd] != max).
  - Accepted issue with issue_rd!=0 increments cnt[issue_rd].
  - issue_rd==0 is accepted with no count change.
  - we=1, rd!=0, cnt[rd]>0: decrements cnt[rd].
  - we=1, rd!=0, cnt[rd]==0: count unchanged, wb_underflow<=1 (sticky until reset). Data still written.
  - Accepted issue and writeback to the same r in one cycle: cnt[r] unchanged, including at cnt=0. The issue's increment and the writeback's decrement net to zero, so no underflow is flagged.
  - Accepted issue and writeback to different registers in one cycle: each updated independently.
  - issue_valid with issue_ready=0: no state change. Decode must hold the issue.
- rsN_busy = (rsN_addr!=0) && (cnt[rsN_addr]!=0). Evaluated on current-cycle counter state, subject to the bypass option below.
- Latency: a write is visible on read ports the cycle after the edge when REGFILE_BYPASS_EN is undefined, and in the same cycle when it is defined.
- No multi-cycle state; reset mid-operation simply drops all pending marks.

Optional Feature:
Macro: REGFILE_BYPASS_EN
- Defined:
  - Write-through forwarding. If we=1, rd!=0 and rd==rsN_addr, then rsN_data=rdValue in the same cycle.
  - rsN_busy is computed as if that writeback's decrement already applied: busy=0 when cnt==1 and no same-cycle accepted issue to that register.
  - Saves one decode stall cycle per dependency.
- Undefined:
  - rsN_data and rsN_busy reflect registered state only.
  - The consumer sees the new value/busy clear one cycle after writeback.

Test Plan:
- Reset then read rs1=5, rs2=0 -> rs1_data=0, rs2_data=0, busy both 0, issue_ready=1, wb_underflow=0.
- Issue rd=3; next cycle rs1_addr=3 -> rs1_busy=1. Writeback we=1 rd=3 rdValue=0xDEADBEEF; following cycle -> rs1_data=0xDEADBEEF, rs1_busy=0. With REGFILE_BYPASS_EN: data and busy=0 in the writeback cycle itself.
- Three issues to rd=7 (PEND_W=2) -> issue_ready=1 for each. Fourth issue_valid to rd=7 -> issue_ready=0, cnt stays 3. Issue to rd=8 same state -> issue_ready=1.
- Same cycle: issue rd=4 and writeback rd=4 value 0x12 with cnt[4]=1 -> cnt[4] stays 1, rs1_busy(4)=1 after edge, regs[4]=0x12, no underflow.
- Writeback rd=0 value 0xFFFFFFFF, issue rd=0 -> rs1_addr=0 reads 0, busy 0, no underflow.
- Writeback rd=9 with cnt[9]=0 -> regs[9] written, wb_underflow=1 and stays 1. Assert rst -> wb_underflow=0 and regs[9]=0 next cycle.
